stcam_array: RTL and testbench

Parametrised ternary CAM array: DEPTH entries of WIDTH ternary bits, each bit storing a value and a don't-care flag, plus a per-entry valid flag. Successor to the single-bit STCAM cell: one write port, one pipelined search port, priority encoding of the lowest-index matching entry. Sits between the lookup controller and the result RAM: the controller presents a key, and the array returns hit, index and full match vector two cycles later.

---
 rtl/stcam_array_pkg.sv | 16 +
 rtl/stcam_array_if.sv | 31 +++
 rtl/stcam_array_entry.sv | 49 ++++
 rtl/stcam_array.sv | 80 ++++++++
 tb/tb_stcam_array.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/stcam_array_pkg.sv
// Shared constants and helpers for the ternary CAM array.
// The package sets the default geometry, the don't-care encoding and the address-width function.
package stcam_array_pkg;

   localparam int   DEF_WIDTH = 8;
   localparam int   DEF_DEPTH = 16;
   localparam logic DC_ON     = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/stcam_array_if.sv
// Write/search/result bus between the lookup controller (master) and the CAM array (slave).
interface stcam_array_if
   import stcam_array_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = clog2(DEPTH)
);
   logic             we;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] wr_dc;
   logic             wr_valid;
   logic             clr_all;
   logic             search_en;
   logic [WIDTH-1:0] search_key;
   logic             match_valid;
   logic             match_hit;
   logic [AW-1:0]    match_addr;
   logic [DEPTH-1:0] match_vec;

   modport master (
      output we, wr_addr, wr_data, wr_dc, wr_valid, clr_all, search_en, search_key,
      input  match_valid, match_hit, match_addr, match_vec
   );

   modport slave (
      input  we, wr_addr, wr_data, wr_dc, wr_valid, clr_all, search_en, search_key,
      output match_valid, match_hit, match_addr, match_vec
   );
endinterface

// File: rtl/stcam_array_entry.sv
// One CAM row: stored value, per-bit don't-care, valid flag and its combinational match against the key.
module stcam_entry
   import stcam_array_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic             clr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [WIDTH-1:0] wr_dc,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] key,
   output logic             match
);
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] dc_q, dc_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] bit_ok;

   // A write to this row overrides a simultaneous clear-all.
   always_comb begin
      data_d  = data_q;
      dc_d    = dc_q;
      valid_d = valid_q;
      if (clr) valid_d = 1'b0;
      if (we) begin
         data_d  = wr_data;
         dc_d    = wr_dc;
         valid_d = wr_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         dc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         dc_q    <= dc_d;
         valid_q <= valid_d;
      end
   end

   assign bit_ok = (dc_q ~^ {WIDTH{DC_ON}}) | (data_q ~^ key);
   assign match  = valid_q & (&bit_ok);
endmodule

// File: rtl/stcam_array.sv
// Ternary CAM array: DEPTH rows, one write port and a two-stage search pipeline
// (compare, then lowest-index priority encode).
module stcam_array
   import stcam_array_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input logic          clk,
   input logic          rst,
   stcam_array_if.slave bus
);
   localparam int AW = clog2(DEPTH);

   logic [DEPTH-1:0] raw_match;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      stcam_entry #(.WIDTH(WIDTH)) u_entry (
         .clk      (clk),
         .rst      (rst),
         .we       (bus.we && (bus.wr_addr == AW'(i))),
         .clr      (bus.clr_all),
         .wr_data  (bus.wr_data),
         .wr_dc    (bus.wr_dc),
         .wr_valid (bus.wr_valid),
         .key      (bus.search_key),
         .match    (raw_match[i])
      );
   end

   logic             s1_valid_q, s1_valid_d;
   logic [DEPTH-1:0] s1_vec_q, s1_vec_d;
   logic             match_valid_q, match_valid_d;
   logic             match_hit_q, match_hit_d;
   logic [AW-1:0]    match_addr_q, match_addr_d;
   logic [DEPTH-1:0] match_vec_q, match_vec_d;
   logic [AW-1:0]    pe_addr;

   // Result registers only move when a search reaches S2, so idle cycles keep the last result.
   always_comb begin
      s1_valid_d    = bus.search_en;
      s1_vec_d      = bus.search_en ? raw_match : s1_vec_q;
      pe_addr       = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (s1_vec_q[i]) pe_addr = AW'(i);
      end
      match_valid_d = s1_valid_q;
      match_hit_d   = match_hit_q;
      match_addr_d  = match_addr_q;
      match_vec_d   = match_vec_q;
      if (s1_valid_q) begin
         match_hit_d  = |s1_vec_q;
         match_addr_d = pe_addr;
         match_vec_d  = s1_vec_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q    <= 1'b0;
         s1_vec_q      <= '0;
         match_valid_q <= 1'b0;
         match_hit_q   <= 1'b0;
         match_addr_q  <= '0;
         match_vec_q   <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_vec_q      <= s1_vec_d;
         match_valid_q <= match_valid_d;
         match_hit_q   <= match_hit_d;
         match_addr_q  <= match_addr_d;
         match_vec_q   <= match_vec_d;
      end
   end

   assign bus.match_valid = match_valid_q;
   assign bus.match_hit   = match_hit_q;
   assign bus.match_addr  = match_addr_q;
   assign bus.match_vec   = match_vec_q;
endmodule

// File: tb/tb_stcam_array.sv
// Directed bench for stcam_array: inputs driven and outputs sampled on the falling edge,
// expected values are hand-computed constants.
module tb_stcam_array;
   logic clk;
   logic rst;
   int   checks_total;
   int   checks_passed;

   stcam_array_if #(.WIDTH(8), .DEPTH(16)) bus ();

   stcam_array #(.WIDTH(8), .DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks_total++;
      assert (observed === expected) checks_passed++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   task automatic checkResult(input string tag, input logic exp_hit, input logic [3:0] exp_addr,
                              input logic [15:0] exp_vec);
      checkOutput({tag, "_valid"}, {31'd0, bus.match_valid}, 32'd1);
      checkOutput({tag, "_hit"},   {31'd0, bus.match_hit},   {31'd0, exp_hit});
      checkOutput({tag, "_addr"},  {28'd0, bus.match_addr},  {28'd0, exp_addr});
      checkOutput({tag, "_vec"},   {16'd0, bus.match_vec},   {16'd0, exp_vec});
   endtask

   task automatic idleInputs();
      bus.we         = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.wr_dc      = '0;
      bus.wr_valid   = 1'b0;
      bus.clr_all    = 1'b0;
      bus.search_en  = 1'b0;
      bus.search_key = '0;
   endtask

   task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data, input logic [7:0] dc,
                                input logic valid);
      @(negedge clk);
      bus.we       = 1'b1;
      bus.wr_addr  = addr;
      bus.wr_data  = data;
      bus.wr_dc    = dc;
      bus.wr_valid = valid;
      @(negedge clk);
      bus.we = 1'b0;
   endtask

   task automatic searchCheck(input string tag, input logic [7:0] key, input logic exp_hit,
                              input logic [3:0] exp_addr, input logic [15:0] exp_vec);
      @(negedge clk);
      bus.search_en  = 1'b1;
      bus.search_key = key;
      @(negedge clk);
      bus.search_en = 1'b0;
      checkOutput({tag, "_s1_novalid"}, {31'd0, bus.match_valid}, 32'd0);
      @(negedge clk);
      checkResult(tag, exp_hit, exp_addr, exp_vec);
      @(negedge clk);
      checkOutput({tag, "_pulse_end"}, {31'd0, bus.match_valid}, 32'd0);
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      idleInputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_valid", {31'd0, bus.match_valid}, 32'd0);
      checkOutput("rst_hit",   {31'd0, bus.match_hit},   32'd0);
      checkOutput("rst_addr",  {28'd0, bus.match_addr},  32'd0);
      checkOutput("rst_vec",   {16'd0, bus.match_vec},   32'd0);

      searchCheck("empty_a5", 8'hA5, 1'b0, 4'd0, 16'h0000);

      applyStimulus(4'd3, 8'hA5, 8'h00, 1'b1);
      applyStimulus(4'd7, 8'hA0, 8'h0F, 1'b1);
      searchCheck("srch_a5", 8'hA5, 1'b1, 4'd3, 16'h0088);
      searchCheck("srch_af", 8'hAF, 1'b1, 4'd7, 16'h0080);

      // Write and search of the same entry in one cycle: search sees old contents.
      @(negedge clk);
      bus.we         = 1'b1;
      bus.wr_addr    = 4'd2;
      bus.wr_data    = 8'h3C;
      bus.wr_dc      = 8'h00;
      bus.wr_valid   = 1'b1;
      bus.search_en  = 1'b1;
      bus.search_key = 8'h3C;
      @(negedge clk);
      bus.we = 1'b0;
      @(negedge clk);
      bus.search_en = 1'b0;
      checkResult("wr_srch_same", 1'b0, 4'd0, 16'h0000);
      @(negedge clk);
      checkResult("wr_srch_next", 1'b1, 4'd2, 16'h0004);

      // Three back-to-back searches.
      @(negedge clk);
      bus.search_en  = 1'b1;
      bus.search_key = 8'hA5;
      @(negedge clk);
      bus.search_key = 8'h00;
      @(negedge clk);
      bus.search_key = 8'hAF;
      checkResult("b2b_0", 1'b1, 4'd3, 16'h0088);
      @(negedge clk);
      bus.search_en = 1'b0;
      checkResult("b2b_1", 1'b0, 4'd0, 16'h0000);
      @(negedge clk);
      checkResult("b2b_2", 1'b1, 4'd7, 16'h0080);
      @(negedge clk);
      checkOutput("b2b_end", {31'd0, bus.match_valid}, 32'd0);
      checkOutput("b2b_hold_addr", {28'd0, bus.match_addr}, 32'd7);

      applyStimulus(4'd0, 8'h00, 8'hFF, 1'b1);
      searchCheck("alldc_12", 8'h12, 1'b1, 4'd0, 16'h0001);
      applyStimulus(4'd0, 8'h00, 8'hFF, 1'b0);
      searchCheck("inval_12", 8'h12, 1'b0, 4'd0, 16'h0000);

      // Clear-all together with a search: the search still sees pre-clear valid flags.
      @(negedge clk);
      bus.clr_all    = 1'b1;
      bus.search_en  = 1'b1;
      bus.search_key = 8'hA5;
      @(negedge clk);
      bus.clr_all   = 1'b0;
      bus.search_en = 1'b0;
      @(negedge clk);
      checkResult("clr_same", 1'b1, 4'd3, 16'h0088);
      searchCheck("clr_after", 8'hA5, 1'b0, 4'd0, 16'h0000);

      @(negedge clk);
      bus.clr_all  = 1'b1;
      bus.we       = 1'b1;
      bus.wr_addr  = 4'd5;
      bus.wr_data  = 8'h55;
      bus.wr_dc    = 8'h00;
      bus.wr_valid = 1'b1;
      @(negedge clk);
      idleInputs();
      searchCheck("clr_wr_wins", 8'h55, 1'b1, 4'd5, 16'h0020);

      // Reset while a search sits in S1.
      applyStimulus(4'd3, 8'hA5, 8'h00, 1'b1);
      @(negedge clk);
      bus.search_en  = 1'b1;
      bus.search_key = 8'hA5;
      @(negedge clk);
      bus.search_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_s1_valid", {31'd0, bus.match_valid}, 32'd0);
      checkOutput("rst_s1_hit",   {31'd0, bus.match_hit},   32'd0);
      checkOutput("rst_s1_addr",  {28'd0, bus.match_addr},  32'd0);
      checkOutput("rst_s1_vec",   {16'd0, bus.match_vec},   32'd0);
      @(negedge clk);
      checkOutput("rst_s1_nopulse", {31'd0, bus.match_valid}, 32'd0);
      searchCheck("post_rst_a5", 8'hA5, 1'b0, 4'd0, 16'h0000);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
